flex_counter_updown: RTL

- Parametrised next-generation flex counter: counts up or down between 1 and a runtime rollover value.
- Supports synchronous clear, synchronous load, and a wrap or saturate mode selected at elaboration.
- Registered rollover/terminal flags are cycle-aligned with count_out, plus a saturating wrap-event counter.
- Serves as a drop-in timing/bit-count primitive for the protocol and datapath blocks in later labs.

---
 rtl/flex_counter_updown.sv | 98 +++++++++
 1 files changed

// File: rtl/flex_counter_updown.sv
// Up/down counter between 1 and a runtime rollover value, with registered terminal flags and a wrap-event counter.
// Latency: every input acts on the next rising edge, outputs purely registered; no backpressure, a step is taken whenever enabled.
module flex_counter_updown #(
  parameter int NUM_CNT_BITS = 4,
  parameter int WRAP_BITS    = 4,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    bottom_flag,
  output logic                    wrap_pulse,
  output logic [WRAP_BITS-1:0]    wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    rollover_flag_q, rollover_flag_d;
  logic                    bottom_flag_q, bottom_flag_d;
  logic                    wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_BITS-1:0]    wrap_count_q, wrap_count_d;
  logic                    wrap_step;

  always_comb begin
    count_d         = count_q;
    rollover_flag_d = 1'b0;
    bottom_flag_d   = 1'b0;
    wrap_pulse_d    = 1'b0;
    wrap_count_d    = wrap_count_q;
    wrap_step       = 1'b0;

    if (clear) begin
      count_d      = '0;
      wrap_count_d = '0;
    end else begin
      if (load) begin
        count_d = load_val;
      end else if (count_enable && (rollover_val != '0)) begin
        if (count_up) begin
          // >= rather than an overflow test: a loaded value above rollover_val wraps too
          if (count_q < rollover_val) begin
            count_d = count_q + ONE;
          end else if (SATURATE != 0) begin
            count_d = rollover_val;
          end else begin
            count_d   = ONE;
            wrap_step = 1'b1;
          end
        end else begin
          if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (SATURATE == 0) begin
            count_d   = rollover_val;
            wrap_step = 1'b1;
          end
        end
      end

      rollover_flag_d = (count_d == rollover_val);
      bottom_flag_d   = (count_d == ONE);
      wrap_pulse_d    = wrap_step;
      if (wrap_step && (wrap_count_q != '1)) begin
        wrap_count_d = wrap_count_q + WRAP_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q         <= '0;
      rollover_flag_q <= 1'b0;
      bottom_flag_q   <= 1'b0;
      wrap_pulse_q    <= 1'b0;
      wrap_count_q    <= '0;
    end else begin
      count_q         <= count_d;
      rollover_flag_q <= rollover_flag_d;
      bottom_flag_q   <= bottom_flag_d;
      wrap_pulse_q    <= wrap_pulse_d;
      wrap_count_q    <= wrap_count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = rollover_flag_q;
  assign bottom_flag   = bottom_flag_q;
  assign wrap_pulse    = wrap_pulse_q;
  assign wrap_count    = wrap_count_q;

endmodule
